// File: rtl/cory_lerp.sv
// Two-tap linear interpolator with a 2-stage valid/ready pipeline and a global stall.
// Optional build macro CORY_LERP_ROUND_EN selects round-half-up instead of truncation.
module cory_lerp #(
  parameter int N = 8,
  parameter int R = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  input  logic [R-1:0] i_a_cnt,
  input  logic [R-1:0] i_a_pos,
  input  logic [7:0]   i_a_phase,
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic [R-1:0] o_z_cnt,
  output logic [R-1:0] o_z_pos,
  input  logic         i_z_r
);

  localparam int MW = N + 9;

  function automatic logic [N-1:0] round_sat(input logic [MW-1:0] sum);
    logic [MW-1:0] biased;
    logic [N:0]    shifted;
`ifdef CORY_LERP_ROUND_EN
    biased = sum + MW'(128);
`else
    biased = sum;
`endif
    shifted = biased[MW-1:8];
    if (shifted[N]) return {N{1'b1}};
    return shifted[N-1:0];
  endfunction

  logic          adv;
  logic          acc;
  logic [N-1:0]  tap_p0;
  logic [8:0]    wgt_a_p0;
  logic [8:0]    wgt_b_p0;
  logic [MW-1:0] mul_a_p0;
  logic [MW-1:0] mul_b_p0;

  logic          vld_p1_d, vld_p1_q;
  logic [MW-1:0] mul_a_p1_d, mul_a_p1_q;
  logic [MW-1:0] mul_b_p1_d, mul_b_p1_q;
  logic [R-1:0]  cnt_p1_d, cnt_p1_q;
  logic [R-1:0]  pos_p1_d, pos_p1_q;
  logic [N-1:0]  prev_d, prev_q;

  logic          vld_p2_d, vld_p2_q;
  logic [N-1:0]  dat_p2_d, dat_p2_q;
  logic [R-1:0]  cnt_p2_d, cnt_p2_q;
  logic [R-1:0]  pos_p2_d, pos_p2_q;

  // Stage 0: tap select and weighted products, straight off the input port
  always_comb begin
    adv      = ~vld_p2_q | i_z_r;
    acc      = i_a_v & adv;
    tap_p0   = (i_a_cnt == '0) ? i_a_d : prev_q;
    wgt_b_p0 = {1'b0, i_a_phase};
    wgt_a_p0 = 9'd256 - wgt_b_p0;
    mul_a_p0 = MW'(tap_p0) * MW'(wgt_a_p0);
    mul_b_p0 = MW'(i_a_d) * MW'(wgt_b_p0);
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    mul_a_p1_d = mul_a_p1_q;
    mul_b_p1_d = mul_b_p1_q;
    cnt_p1_d   = cnt_p1_q;
    pos_p1_d   = pos_p1_q;
    prev_d     = prev_q;
    vld_p2_d   = vld_p2_q;
    dat_p2_d   = dat_p2_q;
    cnt_p2_d   = cnt_p2_q;
    pos_p2_d   = pos_p2_q;
    if (adv) begin
      // Stage 1: capture products; prev only moves on an accepted beat
      vld_p1_d = acc;
      if (acc) begin
        mul_a_p1_d = mul_a_p0;
        mul_b_p1_d = mul_b_p0;
        cnt_p1_d   = i_a_cnt;
        pos_p1_d   = i_a_pos;
        prev_d     = i_a_d;
      end
      // Stage 2: sum, scale by 1/256 and clamp
      vld_p2_d = vld_p1_q;
      dat_p2_d = round_sat(mul_a_p1_q + mul_b_p1_q);
      cnt_p2_d = cnt_p1_q;
      pos_p2_d = pos_p1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      mul_a_p1_q <= '0;
      mul_b_p1_q <= '0;
      cnt_p1_q   <= '0;
      pos_p1_q   <= '0;
      prev_q     <= '0;
      vld_p2_q   <= 1'b0;
      dat_p2_q   <= '0;
      cnt_p2_q   <= '0;
      pos_p2_q   <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      mul_a_p1_q <= mul_a_p1_d;
      mul_b_p1_q <= mul_b_p1_d;
      cnt_p1_q   <= cnt_p1_d;
      pos_p1_q   <= pos_p1_d;
      prev_q     <= prev_d;
      vld_p2_q   <= vld_p2_d;
      dat_p2_q   <= dat_p2_d;
      cnt_p2_q   <= cnt_p2_d;
      pos_p2_q   <= pos_p2_d;
    end
  end

  assign o_a_r   = adv;
  assign o_z_v   = vld_p2_q;
  assign o_z_d   = dat_p2_q;
  assign o_z_cnt = cnt_p2_q;
  assign o_z_pos = pos_p2_q;

endmodule

// File: tb/tb_cory_lerp.sv
// Self-checking bench for cory_lerp: directed vector table, backpressure and reset
// sequences, and randomized traffic scored against an arithmetic reference model.
module tb_cory_lerp;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_a_v;
  logic [7:0]  i_a_d;
  logic [10:0] i_a_cnt;
  logic [10:0] i_a_pos;
  logic [7:0]  i_a_phase;
  logic        o_a_r;
  logic        o_z_v;
  logic [7:0]  o_z_d;
  logic [10:0] o_z_cnt;
  logic [10:0] o_z_pos;
  logic        i_z_r;

  cory_lerp #(.N(8), .R(11)) dut (
    .clk(clk), .reset(reset),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .i_a_cnt(i_a_cnt), .i_a_pos(i_a_pos),
    .i_a_phase(i_a_phase), .o_a_r(o_a_r),
    .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_cnt(o_z_cnt), .o_z_pos(o_z_pos),
    .i_z_r(i_z_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int pos;
    int d;
  } exp_t;

  typedef struct {
    logic [10:0] cnt;
    logic [7:0]  d;
    logic [7:0]  ph;
    int          exp_rnd;
    int          exp_trn;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   model_prev = 0;
  int   n_consumed = 0;
  bit   was_stall = 0;
  int   last_d, last_cnt, last_pos;
  bit   done;
  int   rcnt, line_len, base;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: weighted blend of tap and current sample, scaled by 1/256
  function automatic int model_out(input int p, input int d, input int ph);
    int s;
    s = p * (256 - ph) + d * ph;
`ifdef CORY_LERP_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      was_stall = 0;
    end else begin
      if (o_z_v && i_z_r) begin
        if (q.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_d", int'(o_z_d), e.d);
          check("sb_cnt", int'(o_z_cnt), e.cnt);
          check("sb_pos", int'(o_z_pos), e.pos);
          n_consumed++;
        end
      end
      if (o_z_v && !i_z_r) begin
        check("stall_a_r", int'(o_a_r), 0);
        if (was_stall) begin
          check("stall_d_stable", int'(o_z_d), last_d);
          check("stall_cnt_stable", int'(o_z_cnt), last_cnt);
          check("stall_pos_stable", int'(o_z_pos), last_pos);
        end
        was_stall = 1;
        last_d    = int'(o_z_d);
        last_cnt  = int'(o_z_cnt);
        last_pos  = int'(o_z_pos);
      end else begin
        was_stall = 0;
      end
      if (i_a_v && o_a_r) begin
        exp_t e;
        int   p;
        p     = (i_a_cnt == 0) ? int'(i_a_d) : model_prev;
        e.cnt = int'(i_a_cnt);
        e.pos = int'(i_a_pos);
        e.d   = model_out(p, int'(i_a_d), int'(i_a_phase));
        q.push_back(e);
        model_prev = int'(i_a_d);
      end
    end
  end

  task automatic drive_beat(input logic [10:0] cnt, input logic [10:0] pos,
                            input logic [7:0] d, input logic [7:0] ph);
    bit acc;
    int budget;
    i_a_v = 1'b1; i_a_cnt = cnt; i_a_pos = pos; i_a_d = d; i_a_phase = ph;
    acc = 0; budget = 0;
    while (!acc) begin
      @(negedge clk);
      acc = o_a_r;
      @(posedge clk); #1;
      budget++;
      if (!acc && budget > 100) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    i_a_v = 1'b0;
  endtask

  task automatic send_beat(input string name, input logic [10:0] cnt, input logic [10:0] pos,
                           input logic [7:0] d, input logic [7:0] ph, input int exp);
    drive_beat(cnt, pos, d, ph);
    check({name, "_lat1_v"}, int'(o_z_v), 0);
    @(posedge clk); #1;
    check({name, "_lat2_v"}, int'(o_z_v), 1);
    check({name, "_d"}, int'(o_z_d), exp);
    check({name, "_cnt"}, int'(o_z_cnt), int'(cnt));
    check({name, "_pos"}, int'(o_z_pos), int'(pos));
    @(posedge clk); #1;
    check({name, "_drained_v"}, int'(o_z_v), 0);
  endtask

  task automatic drain(input string name);
    int budget;
    i_z_r = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check({name, "_drain"}, q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{cnt: 11'd1, d: 8'd1,   ph: 8'h80, exp_rnd: 1,   exp_trn: 0};
    vecs[1] = '{cnt: 11'd0, d: 8'd100, ph: 8'h40, exp_rnd: 100, exp_trn: 100};
    vecs[2] = '{cnt: 11'd1, d: 8'd200, ph: 8'h80, exp_rnd: 150, exp_trn: 150};
    vecs[3] = '{cnt: 11'd2, d: 8'd50,  ph: 8'h00, exp_rnd: 200, exp_trn: 200};
    vecs[4] = '{cnt: 11'd3, d: 8'd255, ph: 8'h80, exp_rnd: 153, exp_trn: 152};
    vecs[5] = '{cnt: 11'd0, d: 8'd10,  ph: 8'h80, exp_rnd: 10,  exp_trn: 10};
    vecs[6] = '{cnt: 11'd1, d: 8'd255, ph: 8'hFF, exp_rnd: 254, exp_trn: 254};
    vecs[7] = '{cnt: 11'd2, d: 8'd0,   ph: 8'hFF, exp_rnd: 1,   exp_trn: 0};

    reset = 1'b1; i_a_v = 1'b0; i_a_d = '0; i_a_cnt = '0; i_a_pos = '0;
    i_a_phase = '0; i_z_r = 1'b0;
    #12;
    check("rst_z_v", int'(o_z_v), 0);
    check("rst_a_r", int'(o_a_r), 1);
    check("rst_z_d", int'(o_z_d), 0);
    check("rst_z_cnt", int'(o_z_cnt), 0);
    check("rst_z_pos", int'(o_z_pos), 0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_z_v", int'(o_z_v), 0);
    check("post_rst_a_r", int'(o_a_r), 1);

    i_z_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef CORY_LERP_ROUND_EN
      send_beat($sformatf("vec%0d", i), vecs[i].cnt, 11'(i * 10), vecs[i].d, vecs[i].ph, vecs[i].exp_rnd);
`else
      send_beat($sformatf("vec%0d", i), vecs[i].cnt, 11'(i * 10), vecs[i].d, vecs[i].ph, vecs[i].exp_trn);
`endif
    end

    // Backpressure: four back-to-back beats against a stalled sink
    base = n_consumed;
    fork
      begin
        for (int i = 0; i < 4; i++)
          drive_beat(11'(i), 11'(100 + i), 8'($urandom), 8'($urandom));
      end
      begin
        i_z_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_z_v_held", int'(o_z_v), 1);
        check("bp_a_r_low", int'(o_a_r), 0);
        repeat (4) @(posedge clk);
        #1;
        i_z_r = 1'b1;
      end
    join
    drain("bp");
    check("bp_count", n_consumed - base, 4);

    // Randomized traffic with random gaps and random sink readiness
    base = n_consumed; done = 0; rcnt = 0; line_len = 4;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          if (rcnt >= line_len) begin
            rcnt = 0;
            line_len = $urandom_range(1, 8);
          end
          drive_beat(11'(rcnt), 11'(i), 8'($urandom), 8'($urandom));
          rcnt++;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          i_z_r = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("rand");
    check("rand_count", n_consumed - base, 200);

    // Asynchronous reset while an output is pending
    @(posedge clk); #1;
    i_z_r = 1'b0;
    drive_beat(11'd1, 11'd7, 8'd77, 8'h20);
    drive_beat(11'd2, 11'd8, 8'd99, 8'h40);
    check("mid_z_v_before_rst", int'(o_z_v), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_z_v", int'(o_z_v), 0);
    check("mid_rst_a_r", int'(o_a_r), 1);
    q.delete();
    model_prev = 0;
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    i_z_r = 1'b1;
    check("mid_post_z_v0", int'(o_z_v), 0);
    @(posedge clk); #1;
    check("mid_post_z_v1", int'(o_z_v), 0);
    send_beat("rst_prev0", 11'd5, 11'd42, 8'd80, 8'h80, 40);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cory_lerp.md
Name: cory_lerp

Overview:
- Two-tap linear interpolator. Sits directly downstream of the sampling stage and consumes its tap stream: sample, output count, integer position and 8-bit phase.
- Blends the previous and current samples of the same line using the phase, and emits one filtered sample per input beat.
- Uses a fixed 2-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- N, 8, data bits of input and output samples.
- R, 11, width of count/position fields.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i_a_v  input  1  input beat valid.
- i_a_d  input  N  current sample.
- i_a_cnt  input  R  output index within line; 0 marks the first beat of a line.
- i_a_pos  input  R  integer source position (passed through).
- i_a_phase  input  8  fractional weight of the current sample, 0..255.
- o_a_r  output  1  input ready.
- o_z_v  output  1  output valid.
- o_z_d  output  N  interpolated sample.
- o_z_cnt  output  R  i_a_cnt delayed to match o_z_d.
- o_z_pos  output  R  i_a_pos delayed to match o_z_d.
- i_z_r  input  1  output ready.

Behaviour:
- Reset (asynchronous, active-high):
  - all pipeline valids, data, cnt and pos registers and the prev register go to 0.
  - o_z_v = 0 and o_a_r = 1 once reset is released.
- Handshake:
  - beat accepted when i_a_v & o_a_r; output consumed when o_z_v & i_z_r.
  - adv = ~o_z_v | i_z_r; o_a_r = adv. This is a global stall with no bubble collapse inside the pipe.
- Stage 1 (on accept, when adv):
  - p = (i_a_cnt==0) ? i_a_d : prev.
  - mA = p * (256 - i_a_phase), mB = i_a_d * i_a_phase, each N+9 bits unsigned.
  - s1_v <= 1; cnt/pos registered alongside.
  - prev <= i_a_d.
- Stage 1 when adv with no accept: s1_v <= 0.
- Stage 2 (when adv):
  - sum = mA + mB (N+9 bits) plus rounding term (see Optional Feature).
  - o_z_d <= sum >> 8, saturated to 2^N-1.
  - o_z_v <= s1_v; cnt/pos copied.
- Latency: exactly 2 cycles from accept to o_z_v with no stall. Throughput is 1 beat/cycle.
- Stall (adv = 0): all registers hold. o_z_d, o_z_cnt and o_z_pos stay stable while o_z_v & ~i_z_r.
- Phase weighting: phase 0 outputs p exactly; the current sample never fully dominates, so phase 255 is about 255/256 of the current sample.
- prev rules:
  - prev is only updated on accept, never on stall.
  - cnt==0 overrides prev, giving edge replication at line start.
- Simultaneous accept on the input and consume on the output in the same cycle is legal; the pipe shifts.
- Reset mid-line: pipe contents are discarded. The next beat uses prev = 0 unless its cnt==0.
- Width: the maximum sum is (2^N-1)*256 + 128 < 2^(N+9), so no internal overflow. Saturation is retained as a guard.

Optional Feature:
- Macro: CORY_LERP_ROUND_EN.
- Defined: stage 2 adds 128 before the >>8 (round half up).
- Undefined: no rounding term; result truncates (floor).
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Line start, cnt=0, d=100, phase=0x40, i_z_r=1 -> o_z_d=100 exactly 2 cycles after accept; o_z_cnt=0.
- Follow-on beat, cnt=1, d=200, phase=0x80 (prev=100) -> o_z_d=150. Next beat cnt=2, d=50, phase=0x00 -> o_z_d=200.
- Rounding, prev=0 then cnt=1, d=1, phase=0x80:
  - with CORY_LERP_ROUND_EN -> o_z_d=1.
  - without the macro -> o_z_d=0.
- Backpressure: stream 4 beats, hold i_z_r=0 for 5 cycles ->
  - o_a_r=0 while o_z_v=1;
  - o_z_d/cnt/pos stable throughout;
  - no beat lost or duplicated after release;
  - order and values match the golden model.
- Line boundary, d=255 at cnt=3 then d=10 at cnt=0, phase=0x80 -> o_z_d=10 (prev ignored).
- Async reset asserted mid-stream with o_z_v=1 -> o_z_v=0 immediately. After release, the first beat with cnt=5, d=80, phase=0x80 gives o_z_d=40 (prev=0).
